// File: rtl/wishbone_interconnect_n.sv
// Single-master Wishbone router: adr[31:24] picks slave k, local IRQ block at ADDR_INT, unmapped -> ack with 0.
// Ack two edges after strobe sample; master holds stb until ack; optional watchdog under `WBI_TIMEOUT_EN`.
module wishbone_interconnect_n #(
   parameter int          NUM_SLAVES = 2,
   parameter logic [7:0]  ADDR_INT   = 8'hFF,
   parameter int          TIMEOUT    = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      m_we_i,
   input  logic                      m_cyc_i,
   input  logic                      m_stb_i,
   input  logic [3:0]                m_sel_i,
   input  logic [31:0]               m_adr_i,
   input  logic [31:0]               m_dat_i,
   output logic [31:0]               m_dat_o,
   output logic                      m_ack_o,
   output logic                      m_err_o,
   output logic                      m_int_o,
   output logic [NUM_SLAVES-1:0]     s_we_o,
   output logic [NUM_SLAVES-1:0]     s_cyc_o,
   output logic [NUM_SLAVES-1:0]     s_stb_o,
   output logic [4*NUM_SLAVES-1:0]   s_sel_o,
   output logic [32*NUM_SLAVES-1:0]  s_adr_o,
   output logic [32*NUM_SLAVES-1:0]  s_dat_o,
   input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
   input  logic [NUM_SLAVES-1:0]     s_ack_i,
   input  logic [NUM_SLAVES-1:0]     s_int_i
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT} state_t;
   localparam logic [8:0] NS9 = 9'(NUM_SLAVES);

   state_t                state_q, state_d;
   logic [7:0]            idx_q, idx_d;
   logic [23:0]           off_q, off_d;
   logic                  we_q, we_d;
   logic [3:0]            bsel_q, bsel_d;
   logic [31:0]           wdat_q, wdat_d;
   logic                  act_q, act_d;
   logic [31:0]           dat_q, dat_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  int_q, int_d;
   logic [NUM_SLAVES-1:0] mask_q, mask_d;

   logic [NUM_SLAVES-1:0] slv_oh;
   logic                  ack_hit;
   logic [31:0]           rd_slv, mask_ext, irq_ext, reg_rd;

`ifdef WBI_TIMEOUT_EN
   logic [31:0]           cnt_q, cnt_d;
`else
   logic [31:0]           unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
`endif

   always_comb begin
      slv_oh   = '0;
      rd_slv   = '0;
      mask_ext = '0;
      irq_ext  = '0;
      reg_rd   = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         slv_oh[k]   = act_q && (idx_q == 8'(k));
         if (idx_q == 8'(k)) rd_slv = s_dat_i[32*k +: 32];
         mask_ext[k] = mask_q[k];
         irq_ext[k]  = s_int_i[k];
      end
      ack_hit = |(s_ack_i & slv_oh);
      case (off_q[3:0])
         4'h0:    reg_rd = irq_ext & mask_ext;
         4'h1:    reg_rd = mask_ext;
         4'h2:    reg_rd = irq_ext;
         default: reg_rd = '0;
      endcase
   end

   // Only the latched, selected slave ever sees non-zero request fields.
   always_comb begin
      s_we_o  = '0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (slv_oh[k]) begin
            s_we_o[k]          = we_q;
            s_sel_o[4*k +: 4]  = bsel_q;
            s_adr_o[32*k +: 32] = {8'h00, off_q};
            s_dat_o[32*k +: 32] = wdat_q;
         end
      end
      s_cyc_o = slv_oh;
      s_stb_o = slv_oh;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      off_d   = off_q;
      we_d    = we_q;
      bsel_d  = bsel_q;
      wdat_d  = wdat_q;
      act_d   = act_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      mask_d  = mask_q;
      int_d   = |(s_int_i & mask_q);
`ifdef WBI_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               idx_d  = m_adr_i[31:24];
               off_d  = m_adr_i[23:0];
               we_d   = m_we_i;
               bsel_d = m_sel_i;
               wdat_d = m_dat_i;
               if ({1'b0, m_adr_i[31:24]} < NS9) begin
                  act_d   = 1'b1;
                  state_d = BUSY;
`ifdef WBI_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  state_d = RESP;
               end
            end
         end
         BUSY: begin
            if (!m_cyc_i) begin
               act_d   = 1'b0;
               state_d = IDLE;
            end else if (ack_hit) begin
               dat_d   = rd_slv;
               ack_d   = 1'b1;
               act_d   = 1'b0;
               state_d = RESP;
`ifdef WBI_TIMEOUT_EN
            end else if (cnt_q == 32'(TIMEOUT - 1)) begin
               dat_d   = 32'hDEAD_0000 | {24'h0, idx_q};
               err_d   = 1'b1;
               act_d   = 1'b0;
               state_d = RESP;
            end else begin
               cnt_d   = cnt_q + 32'd1;
`endif
            end
         end
         RESP: begin
            // Slave responses were already acked on the BUSY exit edge.
            if ({1'b0, idx_q} >= NS9) begin
               ack_d = 1'b1;
               if (idx_q == ADDR_INT) begin
                  dat_d = reg_rd;
                  if (we_q && off_q[3:0] == 4'h1) begin
                     for (int k = 0; k < NUM_SLAVES; k++)
                        if (bsel_q[k/8]) mask_d[k] = wdat_q[k];
                  end
               end else begin
                  dat_d = '0;
               end
            end
            state_d = WAIT;
         end
         default: begin
            if (!m_stb_i) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         bsel_q  <= '0;
         wdat_q  <= '0;
         act_q   <= 1'b0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         int_q   <= 1'b0;
         mask_q  <= '0;
`ifdef WBI_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         we_q    <= we_d;
         bsel_q  <= bsel_d;
         wdat_q  <= wdat_d;
         act_q   <= act_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         int_q   <= int_d;
         mask_q  <= mask_d;
`ifdef WBI_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign m_dat_o = dat_q;
   assign m_ack_o = ack_q;
   assign m_err_o = err_q;
   assign m_int_o = int_q;
endmodule

// File: tb/tb_wishbone_interconnect_n.sv
// Randomised bench for wishbone_interconnect_n with behavioural slaves and an interrupt-mask reference model.
module tb_wishbone_interconnect_n;
   localparam int NS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              m_we_i, m_cyc_i, m_stb_i;
   logic [3:0]        m_sel_i;
   logic [31:0]       m_adr_i, m_dat_i;
   logic [31:0]       m_dat_o;
   logic              m_ack_o, m_err_o, m_int_o;
   logic [NS-1:0]     s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_int_i;
   logic [4*NS-1:0]   s_sel_o;
   logic [32*NS-1:0]  s_adr_o, s_dat_o, s_dat_i;

   int                n_chk = 0;
   int                n_pass = 0;
   logic [NS-1:0]     mmask;
   int                slv_dly;
   logic [31:0]       rd_word;
   bit                run = 1'b0;

   always #5 clk = ~clk;

   wishbone_interconnect_n #(.NUM_SLAVES(NS), .ADDR_INT(8'hFF), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_int_o(m_int_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i)
   );

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_m_dat"}, m_dat_o, 0);
      chk({nm, "_m_ack_err_int"}, {m_ack_o, m_err_o, m_int_o}, 0);
      chk({nm, "_s_we_cyc_stb"}, {s_we_o, s_cyc_o, s_stb_o}, 0);
      chk({nm, "_s_sel"}, s_sel_o, 0);
      chk({nm, "_s_adr"}, s_adr_o, 0);
      chk({nm, "_s_dat"}, s_dat_o, 0);
   endtask

   // Expected slave-side view while slave ek (or none, ek<0) holds the bus.
   task automatic chk_slaves(input int ek, input logic [23:0] off, input bit we,
                             input logic [31:0] dat, input logic [3:0] sel);
      logic [NS-1:0]    oh;
      logic [4*NS-1:0]  esel;
      logic [32*NS-1:0] eadr, edat;
      oh = '0; esel = '0; eadr = '0; edat = '0;
      if (ek >= 0) begin
         oh[ek] = 1'b1;
         esel[4*ek +: 4] = sel;
         eadr[32*ek +: 32] = {8'h00, off};
         edat[32*ek +: 32] = dat;
      end
      chk("s_stb", s_stb_o, oh);
      chk("s_cyc", s_cyc_o, oh);
      chk("s_we", s_we_o, we ? oh : '0);
      chk("s_sel", s_sel_o, esel);
      chk("s_adr", s_adr_o, eadr);
      chk("s_dat", s_dat_o, edat);
      chk("m_err_idle", m_err_o, 0);
   endtask

   task automatic txn(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                      input logic [3:0] sel, input int dly, input logic [31:0] rdw, output int lat);
      logic [7:0]  s;
      int          ek;
      logic [31:0] exp, si, mk;
      s  = adr[31:24];
      ek = (s < NS) ? int'(s) : -1;
      si = 32'(s_int_i);
      mk = 32'(mmask);
      if (ek >= 0) exp = rdw;
      else if (s == 8'hFF) begin
         case (adr[3:0])
            4'h0:    exp = si & mk;
            4'h1:    exp = mk;
            4'h2:    exp = si;
            default: exp = 32'h0;
         endcase
      end else exp = 32'h0;
      slv_dly = dly;
      rd_word = rdw;
      @(negedge clk);
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_dat_i = dat; m_sel_i = sel;
      @(posedge clk); #1;
      lat = 0;
      while (!(m_ack_o || m_err_o) && lat < 64) begin
         chk_slaves(ek, adr[23:0], we, dat, sel);
         @(posedge clk); #1;
         lat++;
      end
      chk("ack_seen", m_ack_o, 1);
      chk("latency", lat, (ek >= 0) ? dly + 1 : 1);
      chk("m_err", m_err_o, 0);
      chk("stb_after_ack", s_stb_o, 0);
      if (!we) chk("m_dat", m_dat_o, exp);
      if (we && s == 8'hFF && adr[3:0] == 4'h1 && sel[0]) mmask = dat[NS-1:0];
      @(negedge clk);
      m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
      @(posedge clk); #1;
      chk("ack_pulse", m_ack_o, 0);
      @(posedge clk); #1;
   endtask

   // Behavioural slaves: ack after slv_dly cycles of strobe; idle slaves emit noise acks.
   initial begin
      int wc [NS];
      s_ack_i = '0;
      s_dat_i = '0;
      for (int k = 0; k < NS; k++) wc[k] = 0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NS; k++) begin
            if (s_stb_o[k]) begin
               if (wc[k] >= slv_dly) begin
                  s_ack_i[k] = 1'b1;
                  s_dat_i[32*k +: 32] = rd_word;
               end else begin
                  s_ack_i[k] = 1'b0;
                  s_dat_i[32*k +: 32] = $urandom;
                  wc[k]++;
               end
            end else begin
               wc[k] = 0;
               s_ack_i[k] = 1'($urandom);
               s_dat_i[32*k +: 32] = $urandom;
            end
         end
      end
   end

   // m_int_o must equal the masked-OR of the previous cycle's inputs.
   initial begin
      logic e;
      forever begin
         @(posedge clk);
         e = rst ? |(s_int_i & mmask) : 1'b0;
         if (run) begin
            #1;
            chk("m_int", m_int_o, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int  lt;
      bit  seen;
      rst = 1'b0; m_we_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_sel_i = '0;
      m_adr_i = '0; m_dat_i = '0; s_int_i = '0; mmask = '0; slv_dly = 0; rd_word = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      run = 1'b1;

      // Slave 2 read with one wait cycle.
      txn(32'h0200_0010, 1'b0, 32'h0, 4'hF, 1, 32'hA5A5_0001, lt);
      chk("tp1_dat", m_dat_o, 32'hA5A5_0001);
      chk("tp1_lat", lt, 2);

      // Interrupt mask write, then status/raw/mask reads.
      txn(32'hFF00_0001, 1'b1, 32'h0000_00FF, 4'b0001, 0, 32'h0, lt);
      @(negedge clk);
      s_int_i = 4'b0001;
      @(posedge clk); #1;
      chk("tp2_int", m_int_o, 1);
      txn(32'hFF00_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, lt);
      chk("tp2_status", m_dat_o, 32'h1);
      @(negedge clk);
      s_int_i = 4'b1001;
      txn(32'hFF00_0002, 1'b0, 32'h0, 4'hF, 0, 32'h0, lt);
      chk("tp2_raw", m_dat_o, 32'h9);
      txn(32'hFF00_0001, 1'b1, 32'h0, 4'b1110, 0, 32'h0, lt);
      txn(32'hFF00_0001, 1'b0, 32'h0, 4'hF, 0, 32'h0, lt);
      chk("tp2_mask_bytesel", m_dat_o, 32'hF);

      // Unmapped accesses: no strobe, data 0, write discarded.
      txn(32'h1000_0001, 1'b1, 32'h0, 4'hF, 0, 32'h0, lt);
      txn(32'h1000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, lt);
      chk("tp3_dat", m_dat_o, 32'h0);
      chk("tp3_lat", lt, 1);
      txn(32'hFF00_0001, 1'b0, 32'h0, 4'hF, 0, 32'h0, lt);
      chk("tp3_mask_kept", m_dat_o, 32'hF);

      // Master abort while slave 1 stalls.
      slv_dly = 1000;
      @(negedge clk);
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h0100_0004;
      m_dat_i = 32'h0BAD_F00D; m_sel_i = 4'hF;
      @(posedge clk); #1;
      repeat (3) begin
         chk_slaves(1, 24'h4, 1'b0, 32'h0BAD_F00D, 4'hF);
         @(posedge clk); #1;
      end
      @(negedge clk);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(posedge clk); #1;
      chk("abort_stb", s_stb_o, 0);
      seen = m_ack_o | m_err_o;
      repeat (3) begin
         @(posedge clk); #1;
         seen = seen | m_ack_o | m_err_o;
      end
      chk("abort_noack", seen, 0);

      // Reset in the middle of a second slave-1 transaction.
      @(negedge clk);
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0100_0008;
      @(posedge clk); #1;
      chk("pre_rst_stb", s_stb_o, 4'b0010);
      @(negedge clk);
      rst = 1'b0;
      mmask = '0;
      @(posedge clk); #1;
      chk_zero("mid_rst");
      @(negedge clk);
      m_cyc_i = 1'b0; m_stb_i = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ack", m_ack_o, 0);
      chk("post_rst_stb", s_stb_o, 0);
      txn(32'h0300_ABCD, 1'b0, 32'h0, 4'hF, 2, 32'h3333_0003, lt);

      for (int i = 0; i < 80; i++) begin
         int          c;
         logic [31:0] a;
         c = $urandom_range(0, 3);
         case (c)
            0, 1:    a = {6'b0, 2'($urandom_range(0, 3)), 24'($urandom)};
            2:       a = {8'hFF, 20'($urandom), 4'($urandom_range(0, 5))};
            default: a = {8'($urandom_range(4, 254)), 24'($urandom)};
         endcase
         txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom, lt);
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            s_int_i = 4'($urandom);
         end
      end

`ifdef WBI_TIMEOUT_EN
      slv_dly = 1000;
      @(negedge clk);
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h0000_0000;
      @(posedge clk); #1;
      lt = 0;
      while (!(m_err_o || m_ack_o) && lt < 64) begin
         chk("to_stb", s_stb_o, 4'b0001);
         @(posedge clk); #1;
         lt++;
      end
      chk("to_lat", lt, 16);
      chk("to_err", m_err_o, 1);
      chk("to_ack", m_ack_o, 0);
      chk("to_dat", m_dat_o, 32'hDEAD_0000);
      chk("to_stb_low", s_stb_o, 0);
      @(negedge clk);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(posedge clk); #1;
      chk("to_err_pulse", m_err_o, 0);
      @(posedge clk); #1;
      txn(32'h0000_0020, 1'b0, 32'h0, 4'hF, 1, 32'h1234_5678, lt);
      chk("to_next", m_dat_o, 32'h1234_5678);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
